round_key_generator: RTL and testbench

Key-schedule producer for the AES datapath: accepts a 128/192/256-bit cipher key, expands it one 32-bit word per cycle into an internal word store, then serves 128-bit round keys over the KeyReady/ExpandedKey interface. It delivers rounds 0..Nr in ascending order for encryption, then Nr..0 in descending order for decryption. It is the sending end of the round-key interface driven by the AddRoundKey stage's NextEnc/NextDec requests.

---
 rtl/round_key_generator_if.sv | 22 ++
 rtl/round_key_generator.sv | 166 ++++++++++++++++
 tb/tb_round_key_generator.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/round_key_generator_if.sv
// rtl/round_key_generator_if.sv - key load and round-key delivery bus
interface round_key_generator_if;
   logic         KeyValid;
   logic [0:255] CipherKey;
   logic [3:0]   Nk;
   logic         NextEnc;
   logic         NextDec;
   logic         KeyReady;
   logic [0:127] ExpandedKey;
   logic [3:0]   Nr;
   logic         Busy;

   modport master (
      output KeyValid, CipherKey, Nk, NextEnc, NextDec,
      input  KeyReady, ExpandedKey, Nr, Busy
   );

   modport slave (
      input  KeyValid, CipherKey, Nk, NextEnc, NextDec,
      output KeyReady, ExpandedKey, Nr, Busy
   );
endinterface

// File: rtl/round_key_generator.sv
// rtl/round_key_generator.sv - AES key expansion, one word per cycle, serving round keys enc then dec order
module round_key_sbox (
   input  logic [7:0] byte_i,
   output logic [7:0] byte_o
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte of the table.
   assign byte_o = SBOX_TABLE[11'd2047 - {byte_i, 3'b000} -: 8];
endmodule

module round_key_generator (
   input  logic                   clk,
   input  logic                   rst,
   round_key_generator_if.slave   key_if
);
   typedef enum logic [2:0] {S_IDLE, S_EXPAND, S_ENC, S_DEC, S_DONE} state_e;

   state_e       state_q;
   logic [31:0]  w_q [0:59];
   logic [5:0]   i_q;
   logic [2:0]   m_q;
   logic [7:0]   rcon_q;
   logic [3:0]   nk_q;
   logic [3:0]   ptr_q;
   logic         key_ready_q;
   logic [0:127] key_q;
   logic [3:0]   nr_q;
   logic         busy_q;

   logic [3:0]   nk_sel_d;
   logic [5:0]   last_idx_d;
   logic [31:0]  prev_word_d;
   logic [31:0]  back_word_d;
   logic [31:0]  sb_in_d;
   logic [31:0]  sb_out_d;
   logic [31:0]  temp_d;
   logic [31:0]  w_new_d;
   logic [7:0]   rcon_d;
   logic         m_last_d;
   logic [5:0]   base_d;
   logic [0:127] round_key_d;

   always_comb begin
      nk_sel_d = 4'd4;
      if (key_if.Nk == 4'd6 || key_if.Nk == 4'd8)
         nk_sel_d = key_if.Nk;
      case (nk_q)
         4'd6:    last_idx_d = 6'd51;
         4'd8:    last_idx_d = 6'd59;
         default: last_idx_d = 6'd43;
      endcase
   end

   assign prev_word_d = w_q[i_q - 6'd1];
   assign back_word_d = w_q[i_q - {2'b00, nk_q}];
   assign sb_in_d     = (m_q == 3'd0) ? {prev_word_d[23:0], prev_word_d[31:24]} : prev_word_d;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      round_key_sbox u_sbox (
         .byte_i (sb_in_d[8*b +: 8]),
         .byte_o (sb_out_d[8*b +: 8])
      );
   end

   always_comb begin
      temp_d = prev_word_d;
      if (m_q == 3'd0)
         temp_d = sb_out_d ^ {rcon_q, 24'h000000};
      else if (nk_q == 4'd8 && m_q == 3'd4)
         temp_d = sb_out_d;
   end

   assign w_new_d  = back_word_d ^ temp_d;
   assign rcon_d   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
   assign m_last_d = ({1'b0, m_q} == nk_q - 4'd1);
   assign base_d   = {ptr_q, 2'b00};
   assign round_key_d = {w_q[base_d], w_q[base_d + 6'd1], w_q[base_d + 6'd2], w_q[base_d + 6'd3]};

   // The word store carries no reset; its contents only matter after a key load.
   always_ff @(posedge clk) begin
      if (key_if.KeyValid) begin
         for (int k = 0; k < 8; k++) begin
            if (4'(k) < nk_sel_d)
               w_q[k] <= key_if.CipherKey[32*k +: 32];
         end
      end else if (state_q == S_EXPAND) begin
         w_q[i_q] <= w_new_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         m_q         <= '0;
         rcon_q      <= '0;
         nk_q        <= 4'd4;
         ptr_q       <= '0;
         key_ready_q <= 1'b0;
         key_q       <= '0;
         nr_q        <= '0;
         busy_q      <= 1'b0;
      end else if (key_if.KeyValid) begin
         state_q     <= S_EXPAND;
         nk_q        <= nk_sel_d;
         nr_q        <= nk_sel_d + 4'd6;
         i_q         <= {2'b00, nk_sel_d};
         m_q         <= '0;
         rcon_q      <= 8'h01;
         ptr_q       <= '0;
         key_ready_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         key_ready_q <= 1'b0;
         case (state_q)
            S_EXPAND: begin
               i_q <= i_q + 6'd1;
               m_q <= m_last_d ? 3'd0 : m_q + 3'd1;
               if (m_q == 3'd0)
                  rcon_q <= rcon_d;
               if (i_q == last_idx_d) begin
                  state_q <= S_ENC;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            S_ENC: begin
               if (key_if.NextEnc && !key_ready_q) begin
                  key_ready_q <= 1'b1;
                  key_q       <= round_key_d;
                  if (ptr_q == nr_q)
                     state_q <= S_DEC;
                  else
                     ptr_q <= ptr_q + 4'd1;
               end
            end
            S_DEC: begin
               if (key_if.NextDec && !key_ready_q) begin
                  key_ready_q <= 1'b1;
                  key_q       <= round_key_d;
                  if (ptr_q == 4'd0)
                     state_q <= S_DONE;
                  else
                     ptr_q <= ptr_q - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign key_if.KeyReady    = key_ready_q;
   assign key_if.ExpandedKey = key_q;
   assign key_if.Nr          = nr_q;
   assign key_if.Busy        = busy_q;
endmodule

// File: tb/tb_round_key_generator.sv
// tb/tb_round_key_generator.sv - directed scoreboard bench for round_key_generator
module tb_round_key_generator;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   round_key_generator_if bus ();
   round_key_generator dut (.clk(clk), .rst(rst), .key_if(bus));

   typedef struct {
      logic [127:0] key;
      logic [127:0] mask;
      string        tag;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   localparam logic [127:0] FULL = {128{1'b1}};
   localparam logic [127:0] LOW  = 128'h00000000_00000000_00000000_ffffffff;
   localparam logic [127:0] HIGH = 128'hffffffff_ffffffff_00000000_00000000;

   logic [127:0] k128 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   logic [127:0] k000 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
   logic [191:0] k192 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
   logic [255:0] k256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;
   logic [127:0] r128 [0:10];
   logic [127:0] m128 [0:10];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [127:0] key, input logic [127:0] mask, input string tag);
      exp_t e;
      e.key = key; e.mask = mask; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic start_key(input logic [255:0] key, input logic [3:0] nk);
      bus.CipherKey = key;
      bus.Nk        = nk;
      bus.KeyValid  = 1'b1;
      tick();
      bus.KeyValid  = 1'b0;
   endtask

   task automatic wait_expand(input int exp_cycles, input string tag);
      int cnt = 0;
      int pulses = 0;
      while (bus.Busy === 1'b1 && cnt < 200) begin
         if (bus.KeyReady === 1'b1) pulses++;
         cnt++;
         tick();
      end
      check({tag, " busy cycles"}, cnt, exp_cycles);
      check({tag, " pulses while busy"}, pulses, 0);
   endtask

   task automatic collect(input int n, input bit gaps, input int budget, input string tag);
      int   got = 0;
      int   cyc = 0;
      int   last = 0;
      exp_t e;
      while (got < n && cyc < budget) begin
         tick();
         cyc++;
         if (bus.KeyReady === 1'b1) begin
            if (gaps && got > 0) check({tag, " pulse gap"}, cyc - last, 2);
            last = cyc;
            n_tests++;
            assert (sb.size() > 0) else begin
               n_fail++;
               $error("FAIL %s scoreboard: observed empty queue expected an entry", tag);
            end
            if (sb.size() > 0) begin
               e = sb.pop_front();
               if (e.mask != '0) check(e.tag, bus.ExpandedKey & e.mask, e.key & e.mask);
            end
            got++;
         end
      end
      check({tag, " pulse count"}, got, n);
   endtask

   task automatic no_pulse(input int cycles, input string tag);
      int pulses = 0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (bus.KeyReady !== 1'b0) pulses++;
      end
      check(tag, pulses, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " KeyReady"}, bus.KeyReady, 0);
      check({tag, " Busy"}, bus.Busy, 0);
      check({tag, " Nr"}, bus.Nr, 0);
      check({tag, " ExpandedKey"}, bus.ExpandedKey, 0);
   endtask

   initial begin
      r128[0]  = k128;
      r128[1]  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
      r128[2]  = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
      r128[3]  = 128'h3d80477d_4716fe3e_1e237e44_6d7a883b;
      for (int r = 4; r < 10; r++) r128[r] = '0;
      r128[10] = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
      for (int r = 0; r < 11; r++) m128[r] = (r <= 3 || r == 10) ? FULL : '0;

      bus.KeyValid  = 1'b0;
      bus.CipherKey = '0;
      bus.Nk        = 4'd4;
      bus.NextEnc   = 1'b0;
      bus.NextDec   = 1'b0;

      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b1;
      bus.NextEnc = 1'b1;
      no_pulse(5, "idle request");
      bus.NextEnc = 1'b0;

      // AES-128 encrypt then decrypt order with requests held high
      start_key({k128, 128'h0}, 4'd4);
      bus.NextEnc = 1'b1;
      for (int r = 0; r <= 10; r++) push(r128[r], m128[r], $sformatf("enc128 round %0d", r));
      wait_expand(40, "aes128");
      check("aes128 Nr", bus.Nr, 10);
      collect(11, 1'b1, 60, "enc128");
      no_pulse(6, "NextEnc ignored in DEC");
      bus.NextEnc = 1'b0;
      for (int r = 10; r >= 0; r--) push(r128[r], m128[r], $sformatf("dec128 round %0d", r));
      bus.NextDec = 1'b1;
      collect(11, 1'b1, 60, "dec128");
      no_pulse(6, "DONE ignores requests");
      bus.NextDec = 1'b0;

      // AES-192
      start_key({k192, 64'h0}, 4'd6);
      bus.NextEnc = 1'b1;
      push(k192[191:64], FULL, "enc192 round 0");
      push({k192[63:0], 64'h0}, HIGH, "enc192 round 1");
      for (int r = 2; r < 12; r++) push('0, '0, "enc192 inner");
      push(128'h01002202, LOW, "enc192 w51");
      wait_expand(46, "aes192");
      check("aes192 Nr", bus.Nr, 12);
      collect(13, 1'b1, 80, "enc192");
      bus.NextEnc = 1'b0;

      // AES-256
      start_key(k256, 4'd8);
      bus.NextEnc = 1'b1;
      push(k256[255:128], FULL, "enc256 round 0");
      push(k256[127:0], FULL, "enc256 round 1");
      for (int r = 2; r < 14; r++) push('0, '0, "enc256 inner");
      push(128'h706c631e, LOW, "enc256 w59");
      wait_expand(52, "aes256");
      check("aes256 Nr", bus.Nr, 14);
      collect(15, 1'b1, 80, "enc256");
      bus.NextEnc = 1'b0;

      // Abort mid-expansion, with a request pulse while busy
      start_key({k128, 128'h0}, 4'd4);
      begin
         int busy_pulses = 0;
         for (int c = 1; c < 20; c++) begin
            bus.NextEnc = (c == 10);
            tick();
            if (bus.KeyReady !== 1'b0) busy_pulses++;
         end
         check("request during busy", busy_pulses, 0);
      end
      bus.NextEnc = 1'b0;
      start_key({k000, 128'h0}, 4'd4);
      wait_expand(40, "abort restart");

      // A request held across the KeyReady cycle yields a single key
      push(k000, FULL, "abort round 0");
      bus.NextEnc = 1'b1;
      collect(1, 1'b0, 5, "single request");
      tick();
      check("request masked while ready", bus.KeyReady, 0);
      bus.NextEnc = 1'b0;
      no_pulse(4, "no pulse after release");
      for (int r = 1; r < 10; r++) push('0, '0, "abort inner");
      push(128'h13111d7f_e3944a17_f307a78b_4d2b30c5, FULL, "abort round 10");
      bus.NextEnc = 1'b1;
      collect(10, 1'b1, 60, "abort enc");
      bus.NextEnc = 1'b0;

      // KeyValid coincident with a request, then reset mid-serve
      start_key({k128, 128'h0}, 4'd4);
      bus.NextEnc = 1'b1;
      for (int r = 0; r <= 5; r++) push(r128[r], m128[r], $sformatf("pre-restart round %0d", r));
      wait_expand(40, "pre-restart");
      collect(6, 1'b1, 30, "pre-restart");
      tick();
      bus.CipherKey = {k128, 128'h0};
      bus.Nk        = 4'd4;
      bus.KeyValid  = 1'b1;
      tick();
      bus.KeyValid  = 1'b0;
      check("KeyValid wins KeyReady", bus.KeyReady, 0);
      check("KeyValid wins Busy", bus.Busy, 1);
      wait_expand(40, "restart");
      for (int r = 0; r <= 5; r++) push(r128[r], m128[r], $sformatf("restart round %0d", r));
      collect(6, 1'b1, 30, "restart");
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async reset");
      tick();
      rst = 1'b1;
      no_pulse(20, "request after reset");
      check("busy after reset", bus.Busy, 0);
      bus.NextEnc = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
